// File: rtl/btn_event_pkg.sv
// Shared types and constants for the button gesture decoder.
// The GAP/PRESS2 states are only reachable when BTN_DOUBLE_CLICK_EN is defined.
package btn_event_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS  = 3'd1,
    ST_HELD   = 3'd2,
    ST_GAP    = 3'd3,
    ST_PRESS2 = 3'd4
  } state_t;

  localparam logic [1:0] EV_NONE   = 2'b00;
  localparam logic [1:0] EV_SHORT  = 2'b01;
  localparam logic [1:0] EV_LONG   = 2'b10;
  localparam logic [1:0] EV_DOUBLE = 2'b11;

  localparam int MS_CNT_W = 16;

endpackage

// File: rtl/btn_tick_gen.sv
// Free-running 1 ms tick prescaler: o_tick is high for one cycle every TICK_DIV cycles,
// first asserted so that it is consumed on the TICK_DIV-th clock edge after reset release.
module btn_tick_gen #(
  parameter int TICK_DIV = 25000
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  output logic o_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  assign o_tick = (div_cnt == LAST);

endmodule

// File: rtl/btn_event.sv
// Button gesture decoder: classifies a debounced level into SHORT / LONG (/ DOUBLE when
// BTN_DOUBLE_CLICK_EN is defined) events and presents them on a one-deep valid/ready output.
module btn_event
  import btn_event_pkg::*;
#(
  parameter int TICK_DIV    = 25000,
  parameter int LONG_MS     = 800,
  parameter int DBL_MS      = 250,
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_data,
  output logic [1:0] o_event,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_overrun,
  output logic       o_busy,
  output state_t     o_dbg_state
);

  localparam logic [MS_CNT_W-1:0] LONG_LAST = MS_CNT_W'(LONG_MS - 1);
`ifdef BTN_DOUBLE_CLICK_EN
  localparam logic [MS_CNT_W-1:0] DBL_TH    = MS_CNT_W'(DBL_MS);
  localparam logic [MS_CNT_W-1:0] DBL_LAST  = MS_CNT_W'(DBL_MS - 1);
`endif

  logic                tick;
  logic                pressed_raw;
  logic                pressed_q;
  logic                pressed_d;
  logic                press_edge;
  logic                release_edge;
  logic [MS_CNT_W-1:0] ms_cnt;
  logic                ms_clr;
  state_t              state_q;
  state_t              state_d;
  logic                ev_fire;
  logic [1:0]          ev_code;
  logic                can_load;
  logic                take;

  btn_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .o_tick  (tick)
  );

  assign pressed_raw = ACTIVE_HIGH ? i_data : ~i_data;

  // Both history bits reset to "released" so a button held across reset yields a fresh press.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      pressed_q <= 1'b0;
      pressed_d <= 1'b0;
    end else begin
      pressed_q <= pressed_raw;
      pressed_d <= pressed_q;
    end
  end

  assign press_edge   =  pressed_q & ~pressed_d;
  assign release_edge = ~pressed_q &  pressed_d;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      ms_cnt <= '0;
    end else if (ms_clr) begin
      ms_cnt <= '0;
    end else if (tick && (ms_cnt != '1)) begin
      ms_cnt <= ms_cnt + MS_CNT_W'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Thresholds fire on the tick that carries the count to its limit; edges win over ticks.
  always_comb begin
    state_d = state_q;
    ev_fire = 1'b0;
    ev_code = EV_NONE;
    ms_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press_edge) begin
          state_d = ST_PRESS;
          ms_clr  = 1'b1;
        end
      end
      ST_PRESS: begin
        if (release_edge) begin
`ifdef BTN_DOUBLE_CLICK_EN
          state_d = ST_GAP;
          ms_clr  = 1'b1;
`else
          state_d = ST_IDLE;
          ev_fire = 1'b1;
          ev_code = EV_SHORT;
`endif
        end else if (tick && (ms_cnt == LONG_LAST)) begin
          state_d = ST_HELD;
          ev_fire = 1'b1;
          ev_code = EV_LONG;
        end
      end
      ST_HELD: begin
        if (release_edge) begin
          state_d = ST_IDLE;
        end
      end
`ifdef BTN_DOUBLE_CLICK_EN
      ST_GAP: begin
        if (press_edge && (ms_cnt < DBL_TH)) begin
          state_d = ST_PRESS2;
          ms_clr  = 1'b1;
        end else if (tick && (ms_cnt == DBL_LAST)) begin
          state_d = ST_IDLE;
          ev_fire = 1'b1;
          ev_code = EV_SHORT;
        end
      end
      ST_PRESS2: begin
        if (release_edge) begin
          state_d = ST_IDLE;
          ev_fire = 1'b1;
          ev_code = EV_DOUBLE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake: a transfer happens on any cycle with o_valid && i_ready; i_ready is don't-care
  // while o_valid is low; o_event holds steady while o_valid is high; a new event loads only
  // into an empty or draining slot, otherwise it is dropped and o_overrun pulses for one cycle.
  assign take     = o_valid & i_ready;
  assign can_load = ~o_valid | i_ready;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_event   <= EV_NONE;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (ev_fire) begin
        if (can_load) begin
          o_event <= ev_code;
          o_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (take) begin
        o_valid <= 1'b0;
      end
    end
  end

  assign o_busy      = (state_q != ST_IDLE);
  assign o_dbg_state = state_q;

endmodule

// File: doc/btn_event.md
# btn_event

Button gesture decoder that sits directly downstream of the debounce filter on each push-button. It classifies a debounced button level into short-press, long-press and, optionally, double-click events. Each event is delivered to the UART command/control logic through a valid/ready handshake. A 1 ms tick prescaler sets the time base for all gesture thresholds.

## Interface
- `TICK_DIV`, default 25000: clock cycles per 1 ms tick (25 MHz clock).
- `LONG_MS`, default 800: hold time in ticks that classifies a press as LONG.
- `DBL_MS`, default 250: maximum release gap in ticks between the two presses of a DOUBLE.
- `ACTIVE_HIGH`, default 1: when 1, `i_data`=1 means pressed; when 0, the polarity is inverted.
- `i_Clk`, input, 1: system clock.
- `i_Rst_n`, input, 1: asynchronous active-low reset.
- `i_data`, input, 1: debounced button level, already synchronous to `i_Clk`.
- `o_event`, output, 2: event code (01 SHORT, 10 LONG, 11 DOUBLE), stable while `o_valid` is high.
- `o_valid`, output, 1: an event is pending.
- `i_ready`, input, 1: consumer accepts the event.
- `o_overrun`, output, 1: one-cycle pulse when an event is dropped.
- `o_busy`, output, 1: state machine is not in IDLE.

## Operation
- `i_data` is registered once into `pressed_q` after polarity correction. Press and release are the edges of `pressed_q` against its previous value.
- A ms counter is 16 bits and saturates at all-ones.
  - It clears on entry to PRESS, GAP and PRESS2.
  - It increments on each tick.
- State machine transitions:
  - IDLE: on press edge, go to PRESS.
  - PRESS, count == `LONG_MS` while held: emit LONG, go to HELD.
  - PRESS, release before that: emit SHORT and go to IDLE. With the config macro, go to GAP instead.
  - HELD: on release, go to IDLE. No event is emitted.
  - GAP (macro only), press edge while count < `DBL_MS`: go to PRESS2.
  - GAP, count == `DBL_MS`: emit SHORT, go to IDLE.
  - PRESS2 (macro only): on release, emit DOUBLE and go to IDLE, regardless of how long the second press lasted.
- Event loading into the output register:
  - If `o_valid` is 0, or the current event is being accepted this cycle, the new event is loaded and `o_valid` is 1 next cycle.
  - Otherwise the new event is discarded and `o_overrun` pulses for one cycle. The state machine still advances.
- Handshake:
  - A transfer occurs on a cycle with `o_valid` && `i_ready`.
  - `o_valid` deasserts the following cycle unless a new event loads in the same cycle.
  - `i_ready` is ignored while `o_valid` is 0.
- Reset values:
  - Asserting `i_Rst_n` low immediately forces state IDLE, `o_event`=00, `o_valid`=0, `o_overrun`=0, `o_busy`=0.
  - The tick counter resets to 0, and `pressed_q` and its previous value reset to "released".
- Reset mid-operation: a pending event is lost. A button still held after reset release is seen as a fresh press edge on the first clock.

## Timing
- Input to edge detection takes 1 cycle (`pressed_q` register).
- Decision to `o_valid` takes 1 cycle, so `o_valid` rises 2 cycles after the `i_data` edge for release-triggered events.
- LONG and GAP-timeout events are triggered on the tick cycle where the count reaches its threshold. `o_valid` rises the next cycle.
- The tick pulses for 1 cycle every `TICK_DIV` cycles. It is free-running from reset; its first pulse comes `TICK_DIV` cycles after reset release.
- Threshold resolution is one tick: the measured duration lies between N-1 and N ms.
- An edge and a tick in the same cycle: the edge takes priority, and the counter clears instead of incrementing.

## Configuration
- `BTN_DOUBLE_CLICK_EN` defined: the GAP and PRESS2 states and the DOUBLE code are compiled in. SHORT is delayed by `DBL_MS` after release.
- `BTN_DOUBLE_CLICK_EN` undefined: there are no GAP or PRESS2 states, code 11 is never produced, and SHORT is emitted on release.

## Structure
- `btn_event_pkg` holds:
  - the state enum (IDLE, PRESS, HELD, GAP, PRESS2);
  - the event-code constants (EV_NONE=00, EV_SHORT=01, EV_LONG=10, EV_DOUBLE=11);
  - the ms counter width (16).
- Sub-module `btn_tick_gen`: a parameterised `TICK_DIV` prescaler with inputs `i_Clk` and `i_Rst_n` and a one-cycle `o_tick` output.

## Test plan
Bench uses `TICK_DIV`=4, `LONG_MS`=10, `DBL_MS`=5, `i_ready`=1 unless noted.
- Press 3 ms, then release:
  - macro off: `o_event`=01 valid 2 cycles after the release edge;
  - macro on: `o_event`=01 about 5 ms after release.
- Hold 12 ms: `o_event`=10 valid 1 cycle after the 10th tick while held; no event on release; `o_busy` low after release.
- With the macro, press 2 ms, release 2 ms, press 2 ms, release: exactly one event, 11, and no 01.
- `i_ready`=0, two separate short presses: first event 01 is held stable; the second produces a one-cycle `o_overrun` pulse; raising `i_ready` gives one transfer, then `o_valid`=0.
- Assert `i_Rst_n` mid-hold at 6 ms: outputs go to 0 immediately. Release reset with the button still held, then hold 10 more ms: LONG is reported.
- With `ACTIVE_HIGH`=0, `i_data` held low for 3 ms then high: SHORT (01) is reported.
